i2s_sample_sequencer: RTL and testbench

I2S_SAMPLE_SEQUENCER -- requirements
Module: i2s_sample_sequencer

---
 rtl/i2s_sample_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_i2s_sample_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_sequencer.sv
// i2s_sample_sequencer
//   Buffers packed audio words fetched from memory and hands them out one sample at a time to an
//   I2S writer through a request/ack handshake.
//   - The FIFO holds 2^ADDRESS_WIDTH 32-bit words.
//   - A refill request is issued whenever at least half of the FIFO is free and no refill is
//     outstanding.
//   - 24-bit mode yields one sample per word.
//   - 16-bit mode yields two samples per word, low half first.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   enable              : run when high; when low, flush all state and ignore strobes
//   request_data/size   : one-cycle refill request pulse and the number of words wanted
//   request_finished    : ends the outstanding refill
//   memory_data(_strobe): incoming packed word and its valid strobe
//   audio_data_request  : writer wants the next sample
//   audio_data_ack      : audio_data / audio_channel are valid
//   buffer_level        : words currently buffered
//   underflow/overflow  : sticky error flags, cleared by enable low or rst
//
// Optional feature
//   Define I2S_SEQ_TEST_TONE_EN to add the tone_en input.  While tone_en is high, LOAD returns a
//   per-channel ramp instead of FIFO data.

module i2s_sample_sequencer #(
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned SAMPLE_WIDTH  = 24,
    parameter int unsigned ADDRESS_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
`ifdef I2S_SEQ_TEST_TONE_EN
    input  logic                     tone_en,
`endif
    output logic                     request_data,
    output logic [23:0]              request_size,
    input  logic                     request_finished,
    input  logic                     memory_data_strobe,
    input  logic [31:0]              memory_data,
    input  logic                     audio_data_request,
    output logic                     audio_data_ack,
    output logic [23:0]              audio_data,
    output logic [2:0]               audio_channel,
    output logic [ADDRESS_WIDTH:0]   buffer_level,
    output logic                     underflow,
    output logic                     overflow
);

    localparam int unsigned            Depth    = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] DepthW   = (ADDRESS_WIDTH + 1)'(Depth);
    localparam logic [ADDRESS_WIDTH:0] HalfW    = (ADDRESS_WIDTH + 1)'(Depth / 2);
    localparam logic [2:0]             LastChan = 3'(CHANNELS - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StAck} state_e;

    state_e                   state_q, state_d;
    logic                     ack_q, ack_d;
    logic [23:0]              data_q, data_d;
    logic [2:0]               chan_q, chan_d;
    logic                     under_q, under_d;
    logic                     over_q, over_d;
    logic                     req_q, req_d;
    logic [23:0]              size_q, size_d;
    logic                     pend_q, pend_d;   // refill outstanding
    logic                     half_q, half_d;   // low 16-bit half of head word already used
    logic [ADDRESS_WIDTH:0]   count_q, count_d;
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]              mem_q [Depth];

    logic                     push, pop;
    logic                     fifo_empty, fifo_full;
    logic [ADDRESS_WIDTH:0]   free_space;
    logic [31:0]              rd_word;
    logic                     tone_active;
    logic [23:0]              tone_sample;

`ifdef I2S_SEQ_TEST_TONE_EN
    logic [15:0] ramp_q, ramp_d;
    assign tone_active = tone_en;
    assign tone_sample = {ramp_q + (16'(chan_q) << 12), 8'h00};
`else
    assign tone_active = 1'b0;
    assign tone_sample = '0;
`endif

    always_comb begin
        rd_word    = mem_q[rd_ptr_q];
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DepthW);
        free_space = DepthW - count_q;

        state_d  = state_q;
        ack_d    = ack_q;
        data_d   = data_q;
        chan_d   = chan_q;
        under_d  = under_q;
        over_d   = over_q;
        req_d    = 1'b0;
        size_d   = '0;
        pend_d   = pend_q;
        half_d   = half_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push     = 1'b0;
        pop      = 1'b0;
`ifdef I2S_SEQ_TEST_TONE_EN
        ramp_d   = ramp_q;
`endif

        if (!enable) begin
            state_d  = StIdle;
            ack_d    = 1'b0;
            chan_d   = '0;
            under_d  = 1'b0;
            over_d   = 1'b0;
            pend_d   = 1'b0;
            half_d   = 1'b0;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (audio_data_request && !ack_q) begin
                        state_d = StLoad;
                    end
                end
                StLoad: begin
                    state_d = StAck;
                    ack_d   = 1'b1;
                    if (tone_active) begin
                        data_d = tone_sample;
                    end else if (fifo_empty) begin
                        data_d  = '0;
                        under_d = 1'b1;
                    end else if (SAMPLE_WIDTH == 16) begin
                        if (!half_q) begin
                            data_d = {rd_word[15:0], 8'h00};
                            half_d = 1'b1;
                        end else begin
                            data_d = {rd_word[31:16], 8'h00};
                            half_d = 1'b0;
                            pop    = 1'b1;
                        end
                    end else begin
                        data_d = rd_word[23:0];
                        pop    = 1'b1;
                    end
                end
                StAck: begin
                    if (!audio_data_request) begin
                        state_d = StIdle;
                        ack_d   = 1'b0;
                        chan_d  = (chan_q == LastChan) ? 3'd0 : chan_q + 3'd1;
`ifdef I2S_SEQ_TEST_TONE_EN
                        if (tone_en && chan_q == LastChan) begin
                            ramp_d = ramp_q + 16'd1;
                        end
`endif
                    end
                end
                default: state_d = StIdle;
            endcase

            // A full FIFO can still take a word when the head is leaving this cycle.
            push = memory_data_strobe && (!fifo_full || pop);
            if (memory_data_strobe && !push) begin
                over_d = 1'b1;
            end
            count_d  = count_q + (ADDRESS_WIDTH + 1)'(push) - (ADDRESS_WIDTH + 1)'(pop);
            wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(push);
            rd_ptr_d = rd_ptr_q + ADDRESS_WIDTH'(pop);

            if (pend_q) begin
                if (request_finished) begin
                    pend_d = 1'b0;
                end
            end else if (free_space >= HalfW) begin
                req_d  = 1'b1;
                size_d = 24'(free_space);
                pend_d = 1'b1;
            end
        end
    end

    // Storage has no reset; emptiness is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= memory_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ack_q    <= 1'b0;
            data_q   <= '0;
            chan_q   <= '0;
            under_q  <= 1'b0;
            over_q   <= 1'b0;
            req_q    <= 1'b0;
            size_q   <= '0;
            pend_q   <= 1'b0;
            half_q   <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
`ifdef I2S_SEQ_TEST_TONE_EN
            ramp_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            chan_q   <= chan_d;
            under_q  <= under_d;
            over_q   <= over_d;
            req_q    <= req_d;
            size_q   <= size_d;
            pend_q   <= pend_d;
            half_q   <= half_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
`ifdef I2S_SEQ_TEST_TONE_EN
            ramp_q   <= ramp_d;
`endif
        end
    end

    assign request_data   = req_q;
    assign request_size   = size_q;
    assign audio_data_ack = ack_q;
    assign audio_data     = data_q;
    assign audio_channel  = chan_q;
    assign buffer_level   = count_q;
    assign underflow      = under_q;
    assign overflow       = over_q;

endmodule

// File: tb/tb_i2s_sample_sequencer.sv
// Directed bench for i2s_sample_sequencer.
// Instance dut_a uses the default configuration (2 channels, 24-bit samples, 16-word FIFO).
// Instance dut_b uses the same configuration with 16-bit samples.

module tb_i2s_sample_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;

    logic        req_a, fin_a, stb_a, adr_a, ack_a, unf_a, ovf_a;
    logic [23:0] size_a, data_a;
    logic [31:0] mdata_a;
    logic [2:0]  chan_a;
    logic [4:0]  lvl_a;

    logic        req_b, stb_b, adr_b, ack_b, unf_b, ovf_b;
    logic [23:0] size_b, data_b;
    logic [31:0] mdata_b;
    logic [2:0]  chan_b;
    logic [4:0]  lvl_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    i2s_sample_sequencer #(.CHANNELS(2), .SAMPLE_WIDTH(24), .ADDRESS_WIDTH(4)) dut_a (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
`ifdef I2S_SEQ_TEST_TONE_EN
        .tone_en            (1'b0),
`endif
        .request_data       (req_a),
        .request_size       (size_a),
        .request_finished   (fin_a),
        .memory_data_strobe (stb_a),
        .memory_data        (mdata_a),
        .audio_data_request (adr_a),
        .audio_data_ack     (ack_a),
        .audio_data         (data_a),
        .audio_channel      (chan_a),
        .buffer_level       (lvl_a),
        .underflow          (unf_a),
        .overflow           (ovf_a)
    );

    i2s_sample_sequencer #(.CHANNELS(2), .SAMPLE_WIDTH(16), .ADDRESS_WIDTH(4)) dut_b (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
`ifdef I2S_SEQ_TEST_TONE_EN
        .tone_en            (1'b0),
`endif
        .request_data       (req_b),
        .request_size       (size_b),
        .request_finished   (1'b0),
        .memory_data_strobe (stb_b),
        .memory_data        (mdata_b),
        .audio_data_request (adr_b),
        .audio_data_ack     (ack_b),
        .audio_data         (data_b),
        .audio_channel      (chan_b),
        .buffer_level       (lvl_b),
        .underflow          (unf_b),
        .overflow           (ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full handshake; ack must be low one cycle after request and high the cycle after.
    task automatic read_sample(input bit use_b, input string tag, input logic [23:0] exp_data,
                               input logic [2:0] exp_chan);
        if (use_b) adr_b = 1'b1; else adr_a = 1'b1;
        tick();
        check({tag, "_ack_lo"}, 32'(use_b ? ack_b : ack_a), 32'd0);
        tick();
        check({tag, "_ack_hi"}, 32'(use_b ? ack_b : ack_a), 32'd1);
        check({tag, "_data"}, 32'(use_b ? data_b : data_a), 32'(exp_data));
        check({tag, "_chan"}, 32'(use_b ? chan_b : chan_a), 32'(exp_chan));
        if (use_b) adr_b = 1'b0; else adr_a = 1'b0;
        tick();
        check({tag, "_ack_drop"}, 32'(use_b ? ack_b : ack_a), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        rst = 1'b1; enable = 1'b0;
        fin_a = 1'b0; stb_a = 1'b0; adr_a = 1'b0; mdata_a = '0;
        stb_b = 1'b0; adr_b = 1'b0; mdata_b = '0;

        // Reset state
        #2;
        check("rst_ack", 32'(ack_a), 32'd0);
        check("rst_req", 32'(req_a), 32'd0);
        check("rst_level", 32'(lvl_a), 32'd0);
        check("rst_flags", 32'({unf_a, ovf_a}), 32'd0);
        check("rst_chan", 32'(chan_a), 32'd0);
        check("rst_data", 32'(data_a), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Refill request: one pulse of 16 words, none while outstanding
        enable = 1'b1;
        tick();
        check("refill_pulse", 32'(req_a), 32'd1);
        check("refill_size", 32'(size_a), 32'd16);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (req_a) pulses++;
        end
        check("refill_no_repeat", 32'(pulses), 32'd0);

        // 24-bit unpacking and channel sequencing
        stb_a = 1'b1; mdata_a = 32'h0012_3456;
        tick();
        mdata_a = 32'h80AB_CDEF;
        tick();
        stb_a = 1'b0;
        check("w24_level2", 32'(lvl_a), 32'd2);
        read_sample(1'b0, "w24_s0", 24'h123456, 3'd0);
        check("w24_level1", 32'(lvl_a), 32'd1);
        check("w24_chan_adv", 32'(chan_a), 32'd1);
        read_sample(1'b0, "w24_s1", 24'hABCDEF, 3'd1);
        check("w24_level0", 32'(lvl_a), 32'd0);
        check("w24_chan_wrap", 32'(chan_a), 32'd0);

        // request_finished releases the next refill
        fin_a = 1'b1;
        tick();
        fin_a = 1'b0;
        check("fin_no_pulse_yet", 32'(req_a), 32'd0);
        tick();
        check("fin_new_pulse", 32'(req_a), 32'd1);
        check("fin_new_size", 32'(size_a), 32'd16);

        // 16-bit unpacking: word popped only after its high half
        stb_b = 1'b1; mdata_b = 32'hBEEF_1234;
        tick();
        stb_b = 1'b0;
        check("w16_level_in", 32'(lvl_b), 32'd1);
        read_sample(1'b1, "w16_lo", 24'h123400, 3'd0);
        check("w16_level_mid", 32'(lvl_b), 32'd1);
        read_sample(1'b1, "w16_hi", 24'hBEEF00, 3'd1);
        check("w16_level_out", 32'(lvl_b), 32'd0);

        // Overflow: 17 strobes into a 16-word FIFO
        for (int i = 0; i < 17; i++) begin
            stb_a = 1'b1; mdata_a = 32'h100 + 32'(i);
            tick();
            if (i == 15) check("ovf_not_yet", 32'(ovf_a), 32'd0);
        end
        stb_a = 1'b0;
        check("ovf_level", 32'(lvl_a), 32'd16);
        check("ovf_flag", 32'(ovf_a), 32'd1);
        for (int i = 0; i < 16; i++) begin
            read_sample(1'b0, $sformatf("drain%0d", i), 24'h100 + 24'(i), 3'(i % 2));
        end
        check("drain_level", 32'(lvl_a), 32'd0);
        check("ovf_sticky", 32'(ovf_a), 32'd1);

        // Underflow: the 17th word was dropped, so the next read is empty
        check("unf_before", 32'(unf_a), 32'd0);
        read_sample(1'b0, "empty_rd", 24'h000000, 3'd0);
        check("unf_flag", 32'(unf_a), 32'd1);
        check("unf_chan_adv", 32'(chan_a), 32'd1);

        // Enable low for one cycle flushes everything
        enable = 1'b0;
        tick();
        enable = 1'b1;
        check("flush_unf", 32'(unf_a), 32'd0);
        check("flush_ovf", 32'(ovf_a), 32'd0);
        check("flush_level", 32'(lvl_a), 32'd0);
        check("flush_chan", 32'(chan_a), 32'd0);

        // Asynchronous reset in the middle of ACK
        stb_a = 1'b1; mdata_a = 32'h0077_7777;
        tick();
        stb_a = 1'b0;
        adr_a = 1'b1;
        tick();
        tick();
        check("arst_pre_ack", 32'(ack_a), 32'd1);
        check("arst_pre_data", 32'(data_a), 32'h777777);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ack", 32'(ack_a), 32'd0);
        check("arst_data", 32'(data_a), 32'd0);
        check("arst_level", 32'(lvl_a), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("arst_no_req%0d", i), 32'(req_a), 32'd0);
        end
        rst = 1'b0;
        tick();
        check("arst_restart_idle", 32'(ack_a), 32'd0);
        tick();
        check("arst_restart_ack", 32'(ack_a), 32'd1);
        check("arst_restart_data", 32'(data_a), 32'd0);
        check("arst_restart_unf", 32'(unf_a), 32'd1);
        adr_a = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
